// File: rtl/mem_stage_oq.sv
// mem_stage_oq: memory stage built as an in-order queue of in-flight instructions.
// Instructions from EX are queued. Loads wait for their in-order data_ok response.
// The head entry is offered to WB, and load data reaches WB in the same cycle as
// its response. A flush from WB drops every queued entry. Responses that are still
// owed to flushed loads are counted down and ignored.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   es_to_ms_valid       EX offers an instruction; ms_allowin says MEM takes it
//   es_pc/es_result      instruction PC and ALU result (also the load address)
//   es_rf_we/es_rf_waddr register write enable and destination register
//   es_mem_req           instruction issued a data request expecting one data_ok
//   es_ld_op             one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w, ld_wu, ld_d}
//   es_ex                instruction already carries an exception
//   data_sram_data_ok    in-order response strobe, with data_sram_rdata
//   wb_ex                flush from WB
//   ws_allowin           WB accepts; ms_to_ws_valid offers the head entry
//   ms_pc/ms_rf_we/ms_rf_waddr/ms_rf_wdata/ms_ex  head entry fields
//   ms_pend_mask         destination registers of all queued writers (for ID stall)
module mem_stage_oq #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          es_to_ms_valid,
    output logic          ms_allowin,
    input  logic [31:0]   es_pc,
    input  logic [DW-1:0] es_result,
    input  logic          es_rf_we,
    input  logic [4:0]    es_rf_waddr,
    input  logic          es_mem_req,
    input  logic [6:0]    es_ld_op,
    input  logic          es_ex,
    input  logic          data_sram_data_ok,
    input  logic [DW-1:0] data_sram_rdata,
    input  logic          wb_ex,
    input  logic          ws_allowin,
    output logic          ms_to_ws_valid,
    output logic [31:0]   ms_pc,
    output logic          ms_rf_we,
    output logic [4:0]    ms_rf_waddr,
    output logic [DW-1:0] ms_rf_wdata,
    output logic          ms_ex,
    output logic [31:0]   ms_pend_mask
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned DiscW = CntW + 2;
    localparam int unsigned OffW  = $clog2(DW / 8);

    // Pointer arithmetic modulo DEPTH (DEPTH is a power of two).
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int unsigned k);
        logic [PtrW:0] s;
        s = {1'b0, p} + (PtrW + 1)'(k);
        if (DEPTH == 1) return '0;
        return s[PtrW-1:0];
    endfunction

    // Keep the low 'bits' bits. Fill the upper bits with zero or with the sign bit.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input int unsigned bits,
                                             input logic sgn);
        logic [DW-1:0] r;
        for (int unsigned b = 0; b < DW; b++) begin
            r[b] = (b < bits) ? v[b] : (sgn & v[bits-1]);
        end
        return r;
    endfunction

    // Control state
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wait_q, wait_d;
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [DiscW-1:0] discard_q, discard_d;

    // Entry payload (no reset; only meaningful while the entry is valid)
    logic [31:0]      pc_q     [DEPTH];
    logic [DW-1:0]    result_q [DEPTH];
    logic [DW-1:0]    rdata_q  [DEPTH];
    logic [4:0]       waddr_q  [DEPTH];
    logic [6:0]       ld_op_q  [DEPTH];
    logic [DEPTH-1:0] rf_we_q;
    logic [DEPTH-1:0] ex_q;

    logic            cmp_found;
    logic [PtrW-1:0] cmp_idx;
    logic [PtrW-1:0] search_idx;
    logic [CntW-1:0] num_wait;
    logic            cmp_hit;
    logic            head_valid;
    logic            head_wait;
    logic            head_done;
    logic            offer;
    logic            retire;
    logic            allow;
    logic            enq;
    logic [DiscW-1:0] disc_sum;

    // Find the oldest waiting entry. A response always belongs to this entry.
    always_comb begin
        cmp_found  = 1'b0;
        cmp_idx    = head_q;
        search_idx = '0;
        num_wait   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            search_idx = ptr_add(head_q, i);
            if (valid_q[search_idx] && wait_q[search_idx] && !cmp_found) begin
                cmp_found = 1'b1;
                cmp_idx   = search_idx;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            num_wait = num_wait + CntW'(valid_q[i] & wait_q[i]);
        end
    end

    // A response while draining, or while nothing waits, completes nothing.
    assign cmp_hit    = data_sram_data_ok & (discard_q == '0) & cmp_found;
    assign head_valid = valid_q[head_q];
    assign head_wait  = wait_q[head_q];
    assign head_done  = cmp_hit & (cmp_idx == head_q);
    assign offer      = head_valid & (~head_wait | head_done);
    assign retire     = offer & ws_allowin;
    assign allow      = ~wb_ex & ((count_q < CntW'(DEPTH)) | retire);
    assign enq        = es_to_ms_valid & allow;

    always_comb begin
        valid_d   = valid_q;
        wait_d    = wait_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        discard_d = discard_q;
        disc_sum  = '0;

        if (cmp_hit) wait_d[cmp_idx] = 1'b0;
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_add(head_q, 1);
        end
        // Runs after the retire update: when full, enqueue may reuse the retiring slot.
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            wait_d[tail_q]  = es_mem_req & ~es_ex;
            tail_d          = ptr_add(tail_q, 1);
        end
        count_d = count_q + CntW'(enq) - CntW'(retire);

        if (data_sram_data_ok && discard_q != '0) discard_d = discard_q - DiscW'(1);

        if (wb_ex) begin
            valid_d = '0;
            wait_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            // Responses still owed: already-draining ones plus every waiting entry,
            // less the one arriving right now.
            disc_sum  = discard_q + DiscW'(num_wait);
            discard_d = (data_sram_data_ok && disc_sum != '0) ? disc_sum - DiscW'(1) : disc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q   <= '0;
            wait_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
        end else begin
            valid_q   <= valid_d;
            wait_q    <= wait_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[tail_q]     <= es_pc;
            result_q[tail_q] <= es_result;
            waddr_q[tail_q]  <= es_rf_waddr;
            ld_op_q[tail_q]  <= es_ld_op;
            rf_we_q[tail_q]  <= es_rf_we;
            ex_q[tail_q]     <= es_ex;
        end
        if (cmp_hit) rdata_q[cmp_idx] <= data_sram_rdata;
    end

    // Head write-back data. Load data is bypassed when the head completes this cycle.
    logic [DW-1:0]   h_rdata;
    logic [DW-1:0]   h_result;
    logic [6:0]      h_op;
    logic [OffW+2:0] h_shift;
    logic [DW-1:0]   h_shifted;
    logic [DW-1:0]   load_val;
    logic [DW-1:0]   h_wdata;

    assign h_rdata   = head_wait ? data_sram_rdata : rdata_q[head_q];
    assign h_result  = result_q[head_q];
    assign h_op      = head_valid ? ld_op_q[head_q] : 7'd0;
    assign h_shift   = {h_result[OffW-1:0], 3'b000};
    assign h_shifted = h_rdata >> h_shift;

    always_comb begin
        load_val = h_shifted;
        unique case (1'b1)
            h_op[6]: load_val = extend(h_shifted, 8, 1'b1);
            h_op[5]: load_val = extend(h_shifted, 8, 1'b0);
            h_op[4]: load_val = extend(h_shifted, 16, 1'b1);
            h_op[3]: load_val = extend(h_shifted, 16, 1'b0);
            h_op[2]: load_val = extend(h_shifted, 32, 1'b1);
            h_op[1]: load_val = extend(h_shifted, 32, 1'b0);
            h_op[0]: load_val = h_shifted;
            default: load_val = h_shifted;
        endcase
    end

    assign h_wdata = (h_op != 7'd0) ? load_val : h_result;

    logic [31:0] pend;
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rf_we_q[i] && waddr_q[i] != 5'd0) pend[waddr_q[i]] = 1'b1;
        end
    end

    // Outputs are held at their reset values for as long as resetn is low.
    assign ms_to_ws_valid = resetn & offer;
    assign ms_allowin     = ~resetn | allow;
    assign ms_pc          = (resetn & head_valid) ? pc_q[head_q] : 32'd0;
    assign ms_rf_waddr    = (resetn & head_valid) ? waddr_q[head_q] : 5'd0;
    assign ms_rf_wdata    = (resetn & head_valid) ? h_wdata : '0;
    assign ms_rf_we       = resetn & head_valid & rf_we_q[head_q] & ~ex_q[head_q];
    assign ms_ex          = resetn & head_valid & ex_q[head_q];
    assign ms_pend_mask   = resetn ? pend : 32'd0;

endmodule

// File: tb/tb_mem_stage_oq.sv
module tb_mem_stage_oq;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 32;

    localparam logic [6:0] LD_B  = 7'b1000000;
    localparam logic [6:0] LD_BU = 7'b0100000;
    localparam logic [6:0] LD_H  = 7'b0010000;
    localparam logic [6:0] LD_HU = 7'b0001000;
    localparam logic [6:0] LD_W  = 7'b0000100;
    localparam logic [6:0] LD_WU = 7'b0000010;

    logic          clk = 1'b0;
    logic          resetn;
    logic          es_to_ms_valid;
    logic          ms_allowin;
    logic [31:0]   es_pc;
    logic [DW-1:0] es_result;
    logic          es_rf_we;
    logic [4:0]    es_rf_waddr;
    logic          es_mem_req;
    logic [6:0]    es_ld_op;
    logic          es_ex;
    logic          data_sram_data_ok;
    logic [DW-1:0] data_sram_rdata;
    logic          wb_ex;
    logic          ws_allowin;
    logic          ms_to_ws_valid;
    logic [31:0]   ms_pc;
    logic          ms_rf_we;
    logic [4:0]    ms_rf_waddr;
    logic [DW-1:0] ms_rf_wdata;
    logic          ms_ex;
    logic [31:0]   ms_pend_mask;

    always #5 clk = ~clk;

    mem_stage_oq #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_mem_req        (es_mem_req),
        .es_ld_op          (es_ld_op),
        .es_ex             (es_ex),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_ex             (ms_ex),
        .ms_pend_mask      (ms_pend_mask)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic        rf_we_raw;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic        mem;
        int          enq_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          ready;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    exp_t        cur;
    logic [31:0] cur_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lag      = 0;
    bit auto_rsp  = 1'b0;
    bit toggle_ws = 1'b0;
    bit chk_lat   = 1'b0;
    bit last_enq  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [6:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * addr[1:0]);
        case (op)
            LD_B:    return {{24{sh[7]}}, sh[7:0]};
            LD_BU:   return {24'h0, sh[7:0]};
            LD_H:    return {{16{sh[15]}}, sh[15:0]};
            LD_HU:   return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // One clock: observe/score at negedge, then drive responder at posedge+1.
    task automatic tick();
        exp_t        e;
        rsp_t        r;
        logic [31:0] m;
        @(negedge clk);
        if (!resetn) begin
            chk("rst_valid", 64'(ms_to_ws_valid), 64'(0));
            chk("rst_rf_we", 64'(ms_rf_we), 64'(0));
            chk("rst_ex", 64'(ms_ex), 64'(0));
            chk("rst_pend", 64'(ms_pend_mask), 64'(0));
            chk("rst_allowin", 64'(ms_allowin), 64'(1));
            chk("rst_pc", 64'(ms_pc), 64'(0));
            chk("rst_wdata", 64'(ms_rf_wdata), 64'(0));
            exp_q.delete();
            rsp_q.delete();
            last_enq = 1'b0;
        end else begin
            m = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].rf_we_raw && exp_q[i].waddr != 5'd0) m[exp_q[i].waddr] = 1'b1;
            end
            chk("pend_mask", 64'(ms_pend_mask), 64'(m));
            if (wb_ex) chk("allowin_flush", 64'(ms_allowin), 64'(0));
            else if (exp_q.size() < DEPTH) chk("allowin", 64'(ms_allowin), 64'(1));
            else if (!ws_allowin) chk("allowin_full", 64'(ms_allowin), 64'(0));

            if (ms_to_ws_valid && ws_allowin) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_retire", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", 64'(ms_pc), 64'(e.pc));
                    chk("rf_we", 64'(ms_rf_we), 64'(e.we));
                    chk("waddr", 64'(ms_rf_waddr), 64'(e.waddr));
                    chk("ex", 64'(ms_ex), 64'(e.ex));
                    if (!e.ex) chk("wdata", 64'(ms_rf_wdata), 64'(e.wdata));
                    if (chk_lat) chk("latency", 64'(cyc - e.enq_cyc), 64'(1));
                end
            end

            last_enq = es_to_ms_valid && ms_allowin;
            if (last_enq) begin
                e         = cur;
                e.enq_cyc = cyc;
                exp_q.push_back(e);
                if (cur.mem) begin
                    r.rdata = cur_rdata;
                    r.ready = cyc + 1 + lag;
                    rsp_q.push_back(r);
                end
            end
            if (wb_ex) exp_q.delete();
        end

        @(posedge clk);
        #1;
        cyc++;
        data_sram_data_ok = 1'b0;
        if (auto_rsp && rsp_q.size() > 0 && rsp_q[0].ready <= cyc) begin
            r                 = rsp_q.pop_front();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = r.rdata;
        end
        if (toggle_ws) ws_allowin = ~ws_allowin;
    endtask

    task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                         input logic [31:0] result, input logic mem, input logic [6:0] op,
                         input logic ex, input logic [31:0] rdata);
        es_pc          = pc;
        es_rf_we       = we;
        es_rf_waddr    = waddr;
        es_result      = result;
        es_mem_req     = mem;
        es_ld_op       = op;
        es_ex          = ex;
        es_to_ms_valid = 1'b1;
        cur.pc         = pc;
        cur.rf_we_raw  = we;
        cur.we         = we & ~ex;
        cur.waddr      = waddr;
        cur.ex         = ex;
        cur.mem        = mem & ~ex;
        cur.wdata      = (op != 7'd0) ? ld_model(op, result, rdata) : result;
        cur.enq_cyc    = 0;
        cur_rdata      = rdata;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_enq && n < 50);
        if (!last_enq) chk("enq_timeout", 64'(0), 64'(1));
        if (chk_lat) chk("throughput", 64'(n), 64'(1));
        es_to_ms_valid = 1'b0;
    endtask

    task automatic add_i(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] v);
        drive(pc, 1'b1, waddr, v, 1'b0, 7'd0, 1'b0, 32'd0);
        wait_acc();
    endtask

    task automatic ld(input logic [31:0] pc, input logic [4:0] waddr, input logic [6:0] op,
                      input logic [31:0] addr, input logic [31:0] rdata);
        drive(pc, 1'b1, waddr, addr, 1'b1, op, 1'b0, rdata);
        wait_acc();
    endtask

    task automatic resp_now();
        rsp_t r;
        if (rsp_q.size() == 0) begin
            chk("rsp_underflow", 64'(1), 64'(0));
        end else begin
            r                 = rsp_q.pop_front();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = r.rdata;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [6];
        ops[0] = LD_B; ops[1] = LD_BU; ops[2] = LD_H;
        ops[3] = LD_HU; ops[4] = LD_W; ops[5] = LD_WU;

        resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_result = '0; es_rf_we = 1'b0;
        es_rf_waddr = '0; es_mem_req = 1'b0; es_ld_op = '0; es_ex = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_ex = 1'b0; ws_allowin = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Back-to-back loads, slow responses, WB stalled while the queue is full
        auto_rsp = 1'b1; lag = 3; ws_allowin = 1'b0;
        ld(32'h100, 5'd5, LD_W, 32'h1000, 32'h11);
        ld(32'h104, 5'd6, LD_W, 32'h1004, 32'h22);
        drive(32'h108, 1'b1, 5'd7, 32'h77, 1'b0, 7'd0, 1'b0, 32'd0);
        repeat (5) begin
            tick();
            chk("full_stall", 64'(last_enq), 64'(0));
        end
        ws_allowin = 1'b1;
        wait_acc();
        drain();

        // Byte/half extraction and extension
        lag = 0;
        ld(32'h200, 5'd1, LD_B, 32'h2003, 32'h80FF_FF00);
        ld(32'h204, 5'd2, LD_BU, 32'h2003, 32'h80FF_FF00);
        ld(32'h208, 5'd3, LD_H, 32'h2002, 32'h9234_5678);
        ld(32'h20c, 5'd4, LD_HU, 32'h2002, 32'h9234_5678);
        ld(32'h210, 5'd9, LD_WU, 32'h2000, 32'hDEAD_BEEF);
        drain();

        // Flush with two loads waiting; their responses must be dropped
        auto_rsp = 1'b0;
        ld(32'h300, 5'd8, LD_W, 32'h3000, 32'hA);
        ld(32'h304, 5'd9, LD_W, 32'h3004, 32'hB);
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        ld(32'h308, 5'd10, LD_W, 32'h3008, 32'hC);
        resp_now();
        tick();
        resp_now();
        tick();
        resp_now();
        drain();

        // Flush coinciding with a response: only one later response dropped
        ld(32'h400, 5'd11, LD_W, 32'h4000, 32'h1);
        ld(32'h404, 5'd12, LD_W, 32'h4004, 32'h2);
        wb_ex = 1'b1;
        resp_now();
        tick();
        wb_ex = 1'b0;
        ld(32'h408, 5'd13, LD_W, 32'h4008, 32'h3);
        resp_now();
        tick();
        resp_now();
        drain();
        chk("rsp_left_flush", 64'(rsp_q.size()), 64'(0));

        // Mixed traffic with WB toggling
        auto_rsp = 1'b1; toggle_ws = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  wa;
            logic [31:0] v;
            wa  = (i % 13 == 5) ? 5'd0 : 5'(1 + (i % 31));
            v   = $urandom;
            lag = $urandom_range(0, 2);
            if (i % 9 == 4) begin
                drive(32'h500 + 32'(4 * i), 1'b1, wa, v, 1'b0, 7'd0, 1'b1, 32'd0);
                wait_acc();
            end else if (i % 2 == 0) begin
                add_i(32'h500 + 32'(4 * i), wa, v);
            end else begin
                ld(32'h500 + 32'(4 * i), wa, ops[$urandom_range(0, 5)],
                   32'h5000 + 32'($urandom_range(0, 3)), $urandom);
            end
        end
        toggle_ws = 1'b0; ws_allowin = 1'b1;
        drain();

        // Full throughput and one-cycle offer latency with zero-lag responses
        lag = 0; chk_lat = 1'b1;
        add_i(32'h600, 5'd14, 32'h1234);
        ld(32'h604, 5'd15, LD_W, 32'h6000, 32'hCAFE_F00D);
        add_i(32'h608, 5'd16, 32'h5678);
        ld(32'h60c, 5'd17, LD_H, 32'h6002, 32'h8001_0000);
        ld(32'h610, 5'd18, LD_BU, 32'h6001, 32'h0000_AB00);
        add_i(32'h614, 5'd19, 32'h9abc);
        drain();
        chk_lat = 1'b0;

        // Reset while full with two pending loads
        auto_rsp = 1'b0; ws_allowin = 1'b0;
        ld(32'h700, 5'd20, LD_W, 32'h7000, 32'h55);
        ld(32'h704, 5'd21, LD_W, 32'h7004, 32'h66);
        tick();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1; auto_rsp = 1'b1; ws_allowin = 1'b1;
        add_i(32'h800, 5'd3, 32'h333);
        ld(32'h804, 5'd4, LD_W, 32'h8000, 32'h77);
        drain();
        chk("rsp_left", 64'(rsp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_oq.md
MEM_STAGE_OQ -- requirements
Module: mem_stage_oq

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set in-flight entry count; legal range 1..8, power of two.
REQ-002 Parameter DW, default 32, SHALL set data/result width; legal values 32 or 64.
REQ-003 clk  in  1  clock; resetn  in  1  synchronous, active-low reset.
REQ-004 es_to_ms_valid  in  1  EX offers an instruction; ms_allowin  out  1  MEM accepts this cycle.
REQ-005 es_pc  in  32  instruction PC; es_result  in  DW  ALU result and address.
REQ-006 es_rf_we  in  1  register write enable; es_rf_waddr  in  5  destination register.
REQ-007 es_mem_req  in  1  instruction issued a data request that expects one data_ok.
REQ-008 es_ld_op  in  7  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w, ld_wu, ld_d}; all-zero means not a load.
REQ-009 es_ex  in  1  instruction already carries an exception.
REQ-010 data_sram_data_ok  in  1  in-order response strobe; data_sram_rdata  in  DW  response data.
REQ-011 wb_ex  in  1  flush from WB.
REQ-012 ws_allowin  in  1  WB accepts; ms_to_ws_valid  out  1  head entry offered to WB.
REQ-013 ms_pc  out  32; ms_rf_we  out  1; ms_rf_waddr  out  5; ms_rf_wdata  out  DW; ms_ex  out  1: head entry fields.
REQ-014 ms_pend_mask  out  32  bit r set when any valid entry has rf_we=1 and waddr=r (r≠0); used for ID hazard stall.

Function
REQ-015 Entries SHALL form an in-order circular FIFO with head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-016 ms_allowin SHALL be 1 iff count<DEPTH, or count==DEPTH and the head retires this cycle; ms_allowin SHALL be 0 while wb_ex=1.
REQ-017 Enqueue occurs when es_to_ms_valid & ms_allowin & !wb_ex: the tail is written with wait = es_mem_req & !es_ex.
REQ-018 A data_ok with discard counter 0 SHALL complete the oldest entry with wait=1: rdata is stored and wait is cleared. data_ok while no entry waits and discard=0 is illegal, and the block SHALL ignore it.
REQ-019 The head SHALL be offered (ms_to_ws_valid=1) when valid and wait=0, or in the same cycle data_ok completes the head; zero-bubble bypass of rdata to ms_rf_wdata.
REQ-020 Retire occurs on ms_to_ws_valid & ws_allowin; enqueue and retire SHALL be allowed in the same cycle with count unchanged.
REQ-021 ms_rf_wdata SHALL be: for loads, rdata shifted right by 8*result[log2(DW/8)-1:0] bits and then zero- or sign-extended per ld_op; otherwise the stored result.
REQ-022 ms_ex SHALL equal head ex & head valid; ms_rf_we SHALL equal head rf_we & head valid & !head ex.
REQ-023 On wb_ex all entries SHALL be invalidated next cycle; the discard counter SHALL be loaded with the number of entries with wait=1, minus 1 if data_ok is asserted the same cycle.
REQ-024 While discard>0, each data_ok SHALL decrement discard and SHALL NOT complete any entry; new enqueues SHALL proceed during draining.
REQ-025 Throughput SHALL be one instruction per cycle when responses arrive with 0-cycle lag; latency from enqueue to offer SHALL be 1 cycle for non-memory instructions.

Reset
REQ-026 Under resetn=0 at a clk edge: count, head, tail and discard SHALL be 0 and all entry valid/wait bits cleared.
REQ-027 During and after reset: ms_to_ws_valid=0, ms_rf_we=0, ms_ex=0, ms_pend_mask=0, ms_allowin=1, ms_pc=0, ms_rf_wdata=0.
REQ-028 Reset SHALL override a same-cycle wb_ex or enqueue; responses to requests issued before reset are not tracked.

Verification
REQ-029 DEPTH=2, two ld_w back-to-back to r5 and r6, data_ok after 3 cycles each with rdata 0x11, then 0x22 -> retire in order, wdata 0x11 then 0x22; ms_allowin=0 while full.
REQ-030 ld_b, address low bits 2'b11, rdata 0x80FF_FF00 -> ms_rf_wdata 0xFFFF_FF80; ld_bu gives 0x0000_0080.
REQ-031 Two loads waiting, wb_ex pulse, then a new ld_w enqueued; three data_ok (0xA, 0xB, 0xC) -> first two dropped, new load writes 0xC.
REQ-032 wb_ex and data_ok in the same cycle with 2 waiting -> discard=1; exactly one later response dropped.
REQ-033 Alternating add/ld with ws_allowin toggling 1/0 -> no lost or duplicated retire; ms_pend_mask tracks every queued waddr and clears on retire.
REQ-034 resetn low while full with 2 pending -> all outputs at REQ-027 values; first post-reset enqueue retires correctly.
